// File: rtl/syscall_print_string_if.sv
// Memory-read and character-sink handshakes used by the print-string syscall helper.
interface syscall_print_string_if;
  logic        mem_rd_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic        char_valid;
  logic [7:0]  char_out;
  logic        char_ready;

  modport master (
    output mem_rd_en, mem_addr, char_valid, char_out,
    input  mem_rdata, mem_rvalid, char_ready
  );

  modport slave (
    input  mem_rd_en, mem_addr, char_valid, char_out,
    output mem_rdata, mem_rvalid, char_ready
  );
endinterface

// File: rtl/syscall_print_string.sv
// MIPS print-string syscall engine: walks a NUL-terminated string in data memory
// one word at a time and streams its bytes to a character sink while stalling the pipeline.
module syscall_print_string #(
  parameter int MAX_LEN = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [31:0]           a0,
  syscall_print_string_if.master bus,
  output logic                  stall,
  output logic                  done,
  output logic                  truncated
);

  localparam int CW = $clog2(MAX_LEN + 1);
  localparam logic [CW-1:0] CAP = CW'(MAX_LEN);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    EMIT = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [31:0]     ptr;
  logic [31:0]     ptr_nxt;
  logic [31:0]     ptr_inc;
  logic [31:0]     word_buf;
  logic [31:0]     word_buf_nxt;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_nxt;
  logic [CW-1:0]   count_inc;
  logic            truncated_nxt;
  logic [7:0]      cur_byte;

  assign ptr_inc   = ptr + 32'd1;
  assign count_inc = count + CW'(1);

  // Big-endian byte lane picked by the low pointer bits.
  always_comb begin
    cur_byte = 8'd0;
    case (ptr[1:0])
      2'd0:    cur_byte = word_buf[31:24];
      2'd1:    cur_byte = word_buf[23:16];
      2'd2:    cur_byte = word_buf[15:8];
      2'd3:    cur_byte = word_buf[7:0];
      default: cur_byte = 8'd0;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= 32'd0;
      count     <= '0;
      word_buf  <= 32'd0;
      truncated <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      count     <= count_nxt;
      word_buf  <= word_buf_nxt;
      truncated <= truncated_nxt;
    end
  end

  // Next-state and output decode; stall covers the decode cycle so the pipeline freezes immediately.
  always_comb begin
    state_nxt      = state;
    ptr_nxt        = ptr;
    count_nxt      = count;
    word_buf_nxt   = word_buf;
    truncated_nxt  = truncated;
    bus.mem_rd_en  = 1'b0;
    bus.mem_addr   = 32'd0;
    bus.char_valid = 1'b0;
    bus.char_out   = 8'd0;
    stall          = 1'b0;
    done           = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          ptr_nxt       = a0;
          count_nxt     = '0;
          truncated_nxt = 1'b0;
          stall         = 1'b1;
          state_nxt     = REQ;
        end else begin
          state_nxt = IDLE;
        end
      end

      REQ: begin
        stall         = 1'b1;
        bus.mem_rd_en = 1'b1;
        bus.mem_addr  = {ptr[31:2], 2'b00};
        state_nxt     = WAIT;
      end

      WAIT: begin
        stall = 1'b1;
        if (bus.mem_rvalid) begin
          word_buf_nxt = bus.mem_rdata;
          state_nxt    = EMIT;
        end else begin
          state_nxt = WAIT;
        end
      end

      EMIT: begin
        stall = 1'b1;
        if (cur_byte == 8'd0) begin
          state_nxt = DONE;
        end else begin
          bus.char_valid = 1'b1;
          bus.char_out   = cur_byte;
          if (bus.char_ready) begin
            ptr_nxt   = ptr_inc;
            count_nxt = count_inc;
            if (count_inc == CAP) begin
              truncated_nxt = 1'b1;
              state_nxt     = DONE;
            end else if (ptr_inc[1:0] == 2'b00) begin
              state_nxt = REQ;
            end else begin
              state_nxt = EMIT;
            end
          end else begin
            state_nxt = EMIT;
          end
        end
      end

      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
